// File: rtl/mul_operand_sequencer_if.sv
// Operand-in, multiplier-side and product-out signals
// of the multiplier operand sequencer.
interface mul_operand_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_multiplicand;
   logic [15:0] in_multiplier;
   logic        mul_start;
   logic [15:0] mul_multiplicand;
   logic [15:0] mul_multiplier;
   logic        mul_done;
   logic [31:0] mul_product;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_product;
   logic        err;

   modport master (
      output in_valid, in_multiplicand, in_multiplier,
      output mul_done, mul_product, out_ready,
      input  in_ready, mul_start, mul_multiplicand,
      input  mul_multiplier, out_valid, out_product, err
   );

   modport slave (
      input  in_valid, in_multiplicand, in_multiplier,
      input  mul_done, mul_product, out_ready,
      output in_ready, mul_start, mul_multiplicand,
      output mul_multiplier, out_valid, out_product, err
   );
endinterface

// File: rtl/mul_operand_sequencer.sv
// Operand FIFO and launch/wait sequencer in front of
// the 16x16 shift-add multiplier, with zero bypass.
module mul_operand_sequencer #(
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 64
) (
   input logic clk,
   input logic reset,
   mul_operand_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

   logic [15:0]   mem_a [DEPTH];
   logic [15:0]   mem_b [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          rdy_en;

   state_t        state;
   logic [TW-1:0] tcnt;
   logic          start_q;
   logic [15:0]   a_q;
   logic [15:0]   b_q;
   logic          ov_q;
   logic [31:0]   prod_q;
   logic          err_q;

   logic push;
   logic pop;
   logic slot_free;
   logic head_zero;

   // rdy_en keeps in_ready low until the first edge out of reset
   assign bus.in_ready = rdy_en && (count != FULL);
   assign push      = bus.in_valid && bus.in_ready;
   assign slot_free = !ov_q || bus.out_ready;
   assign pop       = (state == IDLE) && (count != '0)
                      && slot_free;
   assign head_zero = (mem_a[rd_ptr] == '0)
                      || (mem_b[rd_ptr] == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr] <= bus.in_multiplicand;
         mem_b[wr_ptr] <= bus.in_multiplier;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         tcnt    <= '0;
         start_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         ov_q    <= 1'b0;
         prod_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         if (ov_q && bus.out_ready) ov_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pop && head_zero) begin
                  ov_q   <= 1'b1;
                  prod_q <= '0;
               end else if (pop) begin
                  a_q     <= mem_a[rd_ptr];
                  b_q     <= mem_b[rd_ptr];
                  start_q <= 1'b1;
                  state   <= LAUNCH;
               end
            end
            LAUNCH: begin
               tcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (bus.mul_done) begin
                  ov_q   <= 1'b1;
                  prod_q <= bus.mul_product;
                  state  <= IDLE;
               end else if (tcnt == TLAST) begin
                  err_q <= 1'b1;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mul_start        = start_q;
   assign bus.mul_multiplicand = a_q;
   assign bus.mul_multiplier   = b_q;
   assign bus.out_valid        = ov_q;
   assign bus.out_product      = prod_q;
   assign bus.err              = err_q;
endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Randomised bench for mul_operand_sequencer with a
// behavioural multiplier and an in-order product queue.
module tb_mul_operand_sequencer;
   logic clk;
   logic reset;
   mul_operand_sequencer_if mif ();

   mul_operand_sequencer #(.DEPTH(2), .TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .bus(mif)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned cyc = 0;
   int          n_starts = 0;
   int          mul_delay = 5;
   bit          mul_respond = 1'b1;
   bit          rand_delay = 1'b0;
   int unsigned done_cyc = 0;
   logic [31:0] got[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit hit");
      $fatal(1);
   end

   // Multiplier stand-in: done pulse mul_delay cycles
   // after start, stray done pulses while it is idle.
   initial begin : mul_model
      logic [15:0] a, b, opa, opb;
      bit st, busy;
      int k, dly;
      busy = 0; k = 0; dly = 0; opa = 0; opb = 0;
      mif.mul_done = 1'b0;
      mif.mul_product = '0;
      forever begin
         @(negedge clk);
         st = (mif.mul_start === 1'b1);
         a  = mif.mul_multiplicand;
         b  = mif.mul_multiplier;
         @(posedge clk);
         #1;
         mif.mul_done = 1'b0;
         mif.mul_product = $urandom;
         if (reset === 1'b1) begin
            busy = 0;
         end else if (st) begin
            busy = 1; k = 1; opa = a; opb = b;
            dly = rand_delay ? $urandom_range(1, 20)
                             : mul_delay;
         end else if (busy) begin
            k++;
         end
         if (busy && mul_respond && k == dly) begin
            mif.mul_done = 1'b1;
            mif.mul_product = 32'(opa) * 32'(opb);
            busy = 0;
            done_cyc = cyc;
         end else if (!busy && !st
                      && $urandom_range(0, 3) == 0) begin
            mif.mul_done = 1'b1;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (reset === 1'b0) begin
            if (mif.mul_start === 1'b1) n_starts++;
            if (mif.out_valid === 1'b1
                && mif.out_ready === 1'b1)
               got.push_back(mif.out_product);
         end
      end
   end

   function automatic logic [31:0] ref_prod(
      input logic [15:0] a, input logic [15:0] b);
      return 32'(a) * 32'(b);
   endfunction

   function automatic logic [15:0] rand_op(input bit zero);
      if (zero && $urandom_range(0, 4) == 0) return '0;
      return 16'($urandom_range(1, 65535));
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_wait(input logic [15:0] a,
                            input logic [15:0] b,
                            output bit ok);
      int t = 0;
      mif.in_valid = 1'b1;
      mif.in_multiplicand = a;
      mif.in_multiplier = b;
      while (mif.in_ready !== 1'b1 && t < 200) begin
         tick();
         t++;
      end
      ok = (mif.in_ready === 1'b1);
      tick();
      mif.in_valid = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      int t = 0;
      while (mif.mul_start !== 1'b1 && t < 100) begin
         tick();
         t++;
      end
      ok = (mif.mul_start === 1'b1);
   endtask

   task automatic wait_got(input int n, input int budget,
                           output bit ok);
      int t = 0;
      while (got.size() < n && t < budget) begin
         tick();
         t++;
      end
      ok = (got.size() == n);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mif.in_valid = 1'b0;
      mif.in_multiplicand = '0;
      mif.in_multiplier = '0;
      mif.out_ready = 1'b0;
      tick(3);
      n_cmp++;
      if (mif.in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_in_ready: got %b want 0",
                  mif.in_ready);
      end
      n_cmp++;
      if (mif.mul_start !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mul_start: got %b want 0",
                  mif.mul_start);
      end
      n_cmp++;
      if (mif.mul_multiplicand !== 16'h0
          || mif.mul_multiplier !== 16'h0) begin
         n_bad++;
         $display("FAIL rst_operands: got %h/%h want 0/0",
                  mif.mul_multiplicand, mif.mul_multiplier);
      end
      n_cmp++;
      if (mif.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_out_valid: got %b want 0",
                  mif.out_valid);
      end
      n_cmp++;
      if (mif.out_product !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_out_product: got %h want 0",
                  mif.out_product);
      end
      n_cmp++;
      if (mif.err !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_err: got %b want 0", mif.err);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (mif.in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_release_ready: got %b want 0",
                  mif.in_ready);
      end
      tick();
      n_cmp++;
      if (mif.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_first_edge_ready: got %b want 1",
                  mif.in_ready);
      end
   endtask

   task automatic test_single();
      int st_idx, ov_idx, bad_ops, s0;
      int unsigned ovc;
      mul_delay = 40;
      mif.out_ready = 1'b0;
      st_idx = -1; ov_idx = -1; bad_ops = 0; ovc = 0;
      s0 = n_starts;
      got.delete();
      n_cmp++;
      if (mif.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL single_ready: got %b want 1",
                  mif.in_ready);
      end
      mif.in_valid = 1'b1;
      mif.in_multiplicand = 16'd3;
      mif.in_multiplier = 16'd5;
      for (int k = 1; k <= 60; k++) begin
         tick();
         mif.in_valid = 1'b0;
         if (st_idx < 0 && mif.mul_start === 1'b1)
            st_idx = k;
         if (st_idx >= 0
             && (mif.mul_multiplicand !== 16'd3
                 || mif.mul_multiplier !== 16'd5))
            bad_ops++;
         if (ov_idx < 0 && mif.out_valid === 1'b1) begin
            ov_idx = k;
            ovc = cyc;
         end
      end
      n_cmp++;
      if (st_idx != 2) begin
         n_bad++;
         $display("FAIL single_start_cycle: got %0d want 2",
                  st_idx);
      end
      n_cmp++;
      if (n_starts - s0 != 1) begin
         n_bad++;
         $display("FAIL single_start_count: got %0d want 1",
                  n_starts - s0);
      end
      n_cmp++;
      if (bad_ops != 0) begin
         n_bad++;
         $display("FAIL single_operands: %0d bad cycles want 0",
                  bad_ops);
      end
      n_cmp++;
      if (ov_idx != 43) begin
         n_bad++;
         $display("FAIL single_out_cycle: got %0d want 43",
                  ov_idx);
      end
      n_cmp++;
      if (ovc != done_cyc + 1) begin
         n_bad++;
         $display("FAIL single_done_to_out: got %0d want %0d",
                  ovc, done_cyc + 1);
      end
      n_cmp++;
      if (mif.out_valid !== 1'b1
          || mif.out_product !== 32'd15) begin
         n_bad++;
         $display("FAIL single_product: got %b/%0d want 1/15",
                  mif.out_valid, mif.out_product);
      end
      mif.out_ready = 1'b1;
      tick();
      n_cmp++;
      if (mif.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL single_accept: got %b want 0",
                  mif.out_valid);
      end
   endtask

   task automatic test_fifo_full();
      logic [15:0] a[4];
      logic [15:0] b[4];
      logic [31:0] want[4];
      bit ok;
      int t;
      mul_delay = 20;
      mif.out_ready = 1'b1;
      got.delete();
      for (int i = 0; i < 4; i++) begin
         a[i] = rand_op(1'b0);
         b[i] = rand_op(1'b0);
         want[i] = ref_prod(a[i], b[i]);
      end
      push_wait(a[0], b[0], ok);
      wait_start(ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL full_first_start: got 0 want 1");
      end
      mif.in_valid = 1'b1;
      mif.in_multiplicand = a[1];
      mif.in_multiplier = b[1];
      tick();
      mif.in_multiplicand = a[2];
      mif.in_multiplier = b[2];
      tick();
      mif.in_multiplicand = a[3];
      mif.in_multiplier = b[3];
      n_cmp++;
      if (mif.in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL full_ready_low: got %b want 0",
                  mif.in_ready);
      end
      t = 0;
      while (mif.in_ready !== 1'b1 && t < 200) begin
         tick();
         t++;
      end
      n_cmp++;
      if (t != 20) begin
         n_bad++;
         $display("FAIL full_wait: got %0d cycles want 20", t);
      end
      n_cmp++;
      if (mif.mul_start !== 1'b1) begin
         n_bad++;
         $display("FAIL full_refill_at_pop: start %b want 1",
                  mif.mul_start);
      end
      tick();
      mif.in_valid = 1'b0;
      wait_got(4, 500, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL full_count: got %0d want 4",
                  got.size());
      end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== want[i]) begin
            n_bad++;
            $display("FAIL full_order[%0d]: got %h want %h",
                     i, got[i], want[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] a0, b0, a1, b1;
      logic [31:0] hold;
      bit ok;
      int t, s0, bad;
      a0 = rand_op(1'b0); b0 = rand_op(1'b0);
      a1 = rand_op(1'b0); b1 = rand_op(1'b0);
      mul_delay = 5;
      mif.out_ready = 1'b0;
      got.delete();
      push_wait(a0, b0, ok);
      push_wait(a1, b1, ok);
      t = 0;
      while (mif.out_valid !== 1'b1 && t < 100) begin
         tick();
         t++;
      end
      hold = mif.out_product;
      n_cmp++;
      if (hold !== ref_prod(a0, b0)) begin
         n_bad++;
         $display("FAIL bp_first: got %h want %h",
                  hold, ref_prod(a0, b0));
      end
      s0 = n_starts;
      bad = 0;
      repeat (20) begin
         tick();
         if (mif.out_valid !== 1'b1
             || mif.out_product !== hold)
            bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL bp_hold: %0d bad cycles want 0", bad);
      end
      n_cmp++;
      if (n_starts != s0) begin
         n_bad++;
         $display("FAIL bp_no_launch: got %0d starts want 0",
                  n_starts - s0);
      end
      mif.out_ready = 1'b1;
      tick();
      n_cmp++;
      if (mif.mul_start !== 1'b1 || mif.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_b2b: start/valid %b/%b want 1/0",
                  mif.mul_start, mif.out_valid);
      end
      wait_got(2, 200, ok);
      n_cmp++;
      if (!ok || got[1] !== ref_prod(a1, b1)) begin
         n_bad++;
         $display("FAIL bp_second: got %0d items want %h",
                  got.size(), ref_prod(a1, b1));
      end
   endtask

   task automatic test_bypass();
      bit ok;
      int s0;
      mif.out_ready = 1'b1;
      mul_delay = 4;
      got.delete();
      s0 = n_starts;
      mif.in_valid = 1'b1;
      mif.in_multiplicand = 16'd0;
      mif.in_multiplier = 16'd1234;
      tick();
      mif.in_valid = 1'b0;
      n_cmp++;
      if (mif.out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL byp_early: got %b want 0", mif.out_valid);
      end
      tick();
      n_cmp++;
      if (mif.out_valid !== 1'b1
          || mif.out_product !== 32'h0) begin
         n_bad++;
         $display("FAIL byp_out: got %b/%h want 1/0",
                  mif.out_valid, mif.out_product);
      end
      tick(3);
      n_cmp++;
      if (n_starts != s0) begin
         n_bad++;
         $display("FAIL byp_no_start: got %0d want 0",
                  n_starts - s0);
      end
      push_wait(16'd7, 16'd9, ok);
      wait_got(2, 200, ok);
      n_cmp++;
      if (!ok || got[1] !== 32'd63) begin
         n_bad++;
         $display("FAIL byp_next: got %0d items want 63",
                  got.size());
      end
   endtask

   task automatic test_timeout();
      bit ok, ov_seen;
      int rise;
      mul_respond = 1'b0;
      mif.out_ready = 1'b1;
      got.delete();
      push_wait(16'd11, 16'd13, ok);
      wait_start(ok);
      rise = -1;
      ov_seen = 0;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (rise < 0 && mif.err === 1'b1) rise = k;
         if (mif.out_valid === 1'b1) ov_seen = 1;
      end
      n_cmp++;
      if (rise != 65) begin
         n_bad++;
         $display("FAIL to_err_cycle: got %0d want 65", rise);
      end
      n_cmp++;
      if (ov_seen) begin
         n_bad++;
         $display("FAIL to_no_output: got 1 want 0");
      end
      tick(10);
      n_cmp++;
      if (mif.err !== 1'b1) begin
         n_bad++;
         $display("FAIL to_sticky: got %b want 1", mif.err);
      end
      mul_respond = 1'b1;
      mul_delay = 3;
      push_wait(16'd7, 16'd9, ok);
      wait_got(1, 200, ok);
      n_cmp++;
      if (!ok || got[0] !== 32'd63 || mif.err !== 1'b1) begin
         n_bad++;
         $display("FAIL to_next: got %0d items err %b want 63/1",
                  got.size(), mif.err);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int s0;
      mul_delay = 30;
      mif.out_ready = 1'b1;
      push_wait(16'd9, 16'd9, ok);
      wait_start(ok);
      tick(3);
      push_wait(rand_op(1'b0), rand_op(1'b0), ok);
      push_wait(rand_op(1'b0), rand_op(1'b0), ok);
      n_cmp++;
      if (mif.in_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rm_full: got %b want 0", mif.in_ready);
      end
      #3;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (mif.mul_start !== 1'b0 || mif.out_valid !== 1'b0
          || mif.in_ready !== 1'b0 || mif.err !== 1'b0) begin
         n_bad++;
         $display("FAIL rm_ctrl: st/ov/rdy/err %b%b%b%b want 0000",
                  mif.mul_start, mif.out_valid,
                  mif.in_ready, mif.err);
      end
      n_cmp++;
      if (mif.out_product !== 32'h0
          || mif.mul_multiplicand !== 16'h0
          || mif.mul_multiplier !== 16'h0) begin
         n_bad++;
         $display("FAIL rm_data: got %h %h %h want 0 0 0",
                  mif.out_product, mif.mul_multiplicand,
                  mif.mul_multiplier);
      end
      tick();
      reset = 1'b0;
      got.delete();
      s0 = n_starts;
      tick(10);
      n_cmp++;
      if (n_starts != s0 || got.size() != 0) begin
         n_bad++;
         $display("FAIL rm_flushed: got %0d starts %0d outs want 0",
                  n_starts - s0, got.size());
      end
      mul_delay = 6;
      push_wait(16'd2, 16'd2, ok);
      wait_got(1, 200, ok);
      n_cmp++;
      if (!ok || got[0] !== 32'd4) begin
         n_bad++;
         $display("FAIL rm_after: got %0d items want 4",
                  got.size());
      end
   endtask

   task automatic test_random();
      logic [31:0] want[$];
      logic [15:0] a, b;
      int pushed, t;
      bit ok;
      rand_delay = 1'b1;
      got.delete();
      pushed = 0;
      t = 0;
      while ((pushed < 40 || got.size() < 40) && t < 5000) begin
         mif.out_ready = ($urandom_range(0, 3) != 0);
         if (pushed < 40 && $urandom_range(0, 1) == 1) begin
            a = rand_op(1'b1);
            b = rand_op(1'b1);
            mif.in_valid = 1'b1;
            mif.in_multiplicand = a;
            mif.in_multiplier = b;
            if (mif.in_ready === 1'b1) begin
               want.push_back(ref_prod(a, b));
               pushed++;
            end
         end else begin
            mif.in_valid = 1'b0;
         end
         tick();
         t++;
      end
      mif.in_valid = 1'b0;
      mif.out_ready = 1'b1;
      tick(2);
      ok = (got.size() == want.size());
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL rnd_count: got %0d want %0d",
                  got.size(), want.size());
      end
      for (int i = 0; i < want.size() && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== want[i]) begin
            n_bad++;
            $display("FAIL rnd_item[%0d]: got %h want %h",
                     i, got[i], want[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fifo_full();
      test_backpressure();
      test_bypass();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
